// File: rtl/prime_pkg.sv
// Shared types for the prime range scanner: FSM state encoding,
// the 4-bit operand type and the 3-bit prime count type.
package prime_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        FIN  = 2'd2
    } state_t;

    typedef logic [3:0] value_t;
    typedef logic [2:0] count_t;

endpackage

// File: rtl/prime_scanner_if.sv
// Control/result bundle between a run requester (master) and the
// prime range scanner (slave).
interface prime_scanner_if;
    import prime_pkg::*;

    logic   start;
    logic   abort;
    value_t lo;
    value_t hi;
    value_t n;
    logic   valid;
    logic   is_prime;
    count_t count;
    logic   busy;
    logic   done;
    value_t max_prime;

    modport master (
        output start, abort, lo, hi,
        input  n, valid, is_prime, count, busy, done, max_prime
    );

    modport slave (
        input  start, abort, lo, hi,
        output n, valid, is_prime, count, busy, done, max_prime
    );

endinterface

// File: rtl/prime_lut.sv
// Combinational 4-bit prime detector: true for 2, 3, 5, 7, 11 and 13.
module prime_lut
    import prime_pkg::*;
(
    input  value_t value_i,
    output logic   prime_o
);

    // Direct lookup over the sixteen possible operand values
    always_comb begin
        prime_o = 1'b0;
        case (value_i)
            4'd2, 4'd3, 4'd5, 4'd7, 4'd11, 4'd13: prime_o = 1'b1;
            default:                              prime_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/prime_scanner.sv
// Prime range scanner: on start, walks cur from lo to hi (inclusive),
// emitting one registered n/is_prime strobe per step, counting primes,
// and pulsing done once per run.
// Optional feature macro: PRIME_SCANNER_MAXP_EN adds a register that
// tracks the largest prime emitted in the run; without it max_prime is 0.
module prime_scanner
    import prime_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    prime_scanner_if.slave  bus
);

    state_t state_q, state_d;
    value_t cur_q,   cur_d;
    value_t hi_q,    hi_d;
    value_t n_q,     n_d;
    logic   valid_q, valid_d;
    logic   prime_q, prime_d;
    count_t count_q, count_d;
    logic   busy_q,  busy_d;
    logic   done_q,  done_d;

    logic   cur_prime;
    logic   emit;

    prime_lut u_lut (
        .value_i (cur_q),
        .prime_o (cur_prime)
    );

    // A value goes out on every SCAN edge that is not an abort
    assign emit = (state_q == SCAN) && !bus.abort;

    // Next-state and registered-output decode for the scan FSM
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        hi_d    = hi_q;
        n_d     = n_q;
        valid_d = 1'b0;
        prime_d = prime_q;
        count_d = count_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    cur_d   = bus.lo;
                    hi_d    = bus.hi;
                    count_d = '0;
                    state_d = (bus.lo > bus.hi) ? FIN : SCAN;
                end
            end
            SCAN: begin
                if (bus.abort) begin
                    // The abort edge itself raises done, so the pulse lands
                    // in the very next cycle and no separate FIN cycle is spent.
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    n_d     = cur_q;
                    valid_d = 1'b1;
                    prime_d = cur_prime;
                    busy_d  = 1'b1;
                    if (cur_prime) begin
                        count_d = count_q + 3'd1;
                    end
                    // Compare before incrementing so hi=15 never wraps
                    if (cur_q == hi_q) begin
                        state_d = FIN;
                    end else begin
                        cur_d = cur_q + 4'd1;
                    end
                end
            end
            FIN: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cur_q   <= '0;
            hi_q    <= '0;
            n_q     <= '0;
            valid_q <= 1'b0;
            prime_q <= 1'b0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            hi_q    <= hi_d;
            n_q     <= n_d;
            valid_q <= valid_d;
            prime_q <= prime_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.n        = n_q;
    assign bus.valid    = valid_q;
    assign bus.is_prime = prime_q;
    assign bus.count    = count_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

`ifdef PRIME_SCANNER_MAXP_EN
    value_t maxp_q;

    // Largest prime emitted so far; cleared when a run is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            maxp_q <= '0;
        end else if ((state_q == IDLE) && bus.start) begin
            maxp_q <= '0;
        end else if (emit && cur_prime && (cur_q > maxp_q)) begin
            maxp_q <= cur_q;
        end
    end

    assign bus.max_prime = maxp_q;
`else
    assign bus.max_prime = '0;
`endif

endmodule

// File: tb/tb_prime_scanner.sv
// Directed self-checking bench for prime_scanner. Each scenario task drives
// a run, records outputs once per cycle (1 time unit after the rising edge)
// and compares them against hand-derived expectations.
module tb_prime_scanner;
    import prime_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    prime_scanner_if bus ();

    prime_scanner dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int nCompared   = 0;
    int nMismatched = 0;

    logic   obsValid [0:31];
    value_t obsN     [0:31];
    logic   obsPrime [0:31];
    logic   obsBusy  [0:31];
    logic   obsDone  [0:31];
    count_t obsCount [0:31];
    value_t obsMax   [0:31];

    // Expected max_prime for the current build
    function automatic value_t expMax(input int m);
`ifdef PRIME_SCANNER_MAXP_EN
        return value_t'(m);
`else
        return value_t'(0 * m);
`endif
    endfunction

    // Hand-listed prime set of the 4-bit operand space
    function automatic logic refPrime(input int v);
        return (v == 2) || (v == 3) || (v == 5) || (v == 7) || (v == 11) || (v == 13);
    endfunction

    // Present a start request so that it is sampled at the next edge (E0); returns in cycle 0
    task automatic applyStimulus(input value_t lo, input value_t hi);
        bus.lo    = lo;
        bus.hi    = hi;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Record outputs for cycles first..last, sampled 1 unit after each edge
    task automatic captureCycles(input int first, input int last);
        for (int k = first; k <= last; k++) begin
            @(posedge clk);
            #1;
            obsValid[k] = bus.valid;
            obsN[k]     = bus.n;
            obsPrime[k] = bus.is_prime;
            obsBusy[k]  = bus.busy;
            obsDone[k]  = bus.done;
            obsCount[k] = bus.count;
            obsMax[k]   = bus.max_prime;
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.lo    = '0;
        bus.hi    = '0;
        repeat (2) @(posedge clk);
        #1;
        nCompared++;
        if ({bus.valid, bus.is_prime, bus.busy, bus.done} !== 4'b0000) begin
            nMismatched++;
            $display("[TB] FAIL reset.flags: got %b expected 0000", {bus.valid, bus.is_prime, bus.busy, bus.done});
        end
        nCompared++;
        if ({bus.n, bus.count, bus.max_prime} !== 11'd0) begin
            nMismatched++;
            $display("[TB] FAIL reset.values: n=%0d count=%0d max=%0d expected all 0", bus.n, bus.count, bus.max_prime);
        end
        #2 rst = 1'b0;
        captureCycles(0, 1);
        nCompared++;
        if ({obsValid[1], obsBusy[1], obsDone[1]} !== 3'b000) begin
            nMismatched++;
            $display("[TB] FAIL reset.idle: got %b expected 000", {obsValid[1], obsBusy[1], obsDone[1]});
        end
    endtask

    task automatic test_full_range();
        int tally;
        applyStimulus(4'd0, 4'd15);
        captureCycles(1, 19);
        tally = 0;
        for (int k = 1; k <= 19; k++) begin
            logic expOn;
            expOn = (k <= 16);
            if (expOn && refPrime(k - 1)) tally++;
            nCompared++;
            if (obsValid[k] !== expOn || obsBusy[k] !== expOn) begin
                nMismatched++;
                $display("[TB] FAIL full.valid_busy cycle %0d: got %b/%b expected %b", k, obsValid[k], obsBusy[k], expOn);
            end
            nCompared++;
            if (obsDone[k] !== (k == 17)) begin
                nMismatched++;
                $display("[TB] FAIL full.done cycle %0d: got %b expected %b", k, obsDone[k], (k == 17));
            end
            nCompared++;
            if (obsCount[k] !== count_t'(tally)) begin
                nMismatched++;
                $display("[TB] FAIL full.count cycle %0d: got %0d expected %0d", k, obsCount[k], tally);
            end
            if (expOn) begin
                nCompared++;
                if (obsN[k] !== value_t'(k - 1) || obsPrime[k] !== refPrime(k - 1)) begin
                    nMismatched++;
                    $display("[TB] FAIL full.n cycle %0d: got n=%0d p=%b expected n=%0d p=%b", k, obsN[k], obsPrime[k], k - 1, refPrime(k - 1));
                end
            end
        end
        nCompared++;
        if (obsCount[19] !== 3'd6 || obsMax[19] !== expMax(13)) begin
            nMismatched++;
            $display("[TB] FAIL full.final: got count=%0d max=%0d expected 6/%0d", obsCount[19], obsMax[19], expMax(13));
        end
    endtask

    task automatic test_no_primes();
        applyStimulus(4'd8, 4'd10);
        captureCycles(1, 6);
        for (int k = 1; k <= 6; k++) begin
            nCompared++;
            if (obsValid[k] !== (k <= 3) || obsDone[k] !== (k == 4)) begin
                nMismatched++;
                $display("[TB] FAIL noprime.strobe cycle %0d: got v=%b d=%b expected v=%b d=%b", k, obsValid[k], obsDone[k], (k <= 3), (k == 4));
            end
            if (k <= 3) begin
                nCompared++;
                if (obsN[k] !== value_t'(7 + k) || obsPrime[k] !== 1'b0) begin
                    nMismatched++;
                    $display("[TB] FAIL noprime.n cycle %0d: got n=%0d p=%b expected n=%0d p=0", k, obsN[k], obsPrime[k], 7 + k);
                end
            end
        end
        nCompared++;
        if (obsCount[6] !== 3'd0 || obsMax[6] !== 4'd0) begin
            nMismatched++;
            $display("[TB] FAIL noprime.final: got count=%0d max=%0d expected 0/0", obsCount[6], obsMax[6]);
        end
    endtask

    task automatic test_empty_range();
        applyStimulus(4'd9, 4'd3);
        captureCycles(1, 4);
        for (int k = 1; k <= 4; k++) begin
            nCompared++;
            if (obsValid[k] !== 1'b0 || obsBusy[k] !== 1'b0 || obsDone[k] !== (k == 1)) begin
                nMismatched++;
                $display("[TB] FAIL empty.flags cycle %0d: got v=%b b=%b d=%b expected v=0 b=0 d=%b", k, obsValid[k], obsBusy[k], obsDone[k], (k == 1));
            end
        end
        nCompared++;
        if (obsCount[4] !== 3'd0) begin
            nMismatched++;
            $display("[TB] FAIL empty.count: got %0d expected 0", obsCount[4]);
        end
    endtask

    task automatic test_abort();
        applyStimulus(4'd0, 4'd15);
        captureCycles(1, 3);
        bus.abort = 1'b1;
        captureCycles(4, 4);
        bus.abort = 1'b0;
        captureCycles(5, 7);
        for (int k = 1; k <= 7; k++) begin
            nCompared++;
            if (obsValid[k] !== (k <= 3) || obsBusy[k] !== (k <= 3) || obsDone[k] !== (k == 4)) begin
                nMismatched++;
                $display("[TB] FAIL abort.flags cycle %0d: got v=%b b=%b d=%b expected v=%b b=%b d=%b", k, obsValid[k], obsBusy[k], obsDone[k], (k <= 3), (k <= 3), (k == 4));
            end
            if (k <= 3) begin
                nCompared++;
                if (obsN[k] !== value_t'(k - 1)) begin
                    nMismatched++;
                    $display("[TB] FAIL abort.n cycle %0d: got %0d expected %0d", k, obsN[k], k - 1);
                end
            end
        end
        nCompared++;
        if (obsCount[7] !== 3'd1 || obsMax[7] !== expMax(2)) begin
            nMismatched++;
            $display("[TB] FAIL abort.final: got count=%0d max=%0d expected 1/%0d", obsCount[7], obsMax[7], expMax(2));
        end
    endtask

    task automatic test_single();
        applyStimulus(4'd13, 4'd13);
        captureCycles(1, 4);
        for (int k = 1; k <= 4; k++) begin
            nCompared++;
            if (obsValid[k] !== (k == 1) || obsDone[k] !== (k == 2)) begin
                nMismatched++;
                $display("[TB] FAIL single.flags cycle %0d: got v=%b d=%b expected v=%b d=%b", k, obsValid[k], obsDone[k], (k == 1), (k == 2));
            end
        end
        nCompared++;
        if (obsN[1] !== 4'd13 || obsPrime[1] !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL single.n: got n=%0d p=%b expected n=13 p=1", obsN[1], obsPrime[1]);
        end
        nCompared++;
        if (obsCount[4] !== 3'd1 || obsMax[4] !== expMax(13)) begin
            nMismatched++;
            $display("[TB] FAIL single.final: got count=%0d max=%0d expected 1/%0d", obsCount[4], obsMax[4], expMax(13));
        end
    endtask

    task automatic test_back_to_back_start_and_reset();
        applyStimulus(4'd0, 4'd15);
        captureCycles(1, 3);
        bus.start = 1'b1;
        bus.lo    = 4'd5;
        bus.hi    = 4'd7;
        captureCycles(4, 4);
        bus.start = 1'b0;
        captureCycles(5, 6);
        for (int k = 1; k <= 6; k++) begin
            nCompared++;
            if (obsValid[k] !== 1'b1 || obsN[k] !== value_t'(k - 1)) begin
                nMismatched++;
                $display("[TB] FAIL ignore.n cycle %0d: got v=%b n=%0d expected v=1 n=%0d", k, obsValid[k], obsN[k], k - 1);
            end
        end
        rst = 1'b1;
        #1;
        nCompared++;
        if ({bus.valid, bus.is_prime, bus.busy, bus.done, bus.n, bus.count, bus.max_prime} !== 15'd0) begin
            nMismatched++;
            $display("[TB] FAIL midreset.outputs: got v=%b p=%b b=%b d=%b n=%0d c=%0d m=%0d expected all 0", bus.valid, bus.is_prime, bus.busy, bus.done, bus.n, bus.count, bus.max_prime);
        end
        @(posedge clk);
        #2 rst = 1'b0;
        captureCycles(1, 3);
        for (int k = 1; k <= 3; k++) begin
            nCompared++;
            if (obsDone[k] !== 1'b0 || obsValid[k] !== 1'b0) begin
                nMismatched++;
                $display("[TB] FAIL midreset.quiet cycle %0d: got d=%b v=%b expected 0/0", k, obsDone[k], obsValid[k]);
            end
        end
        test_full_range();
    endtask

    initial begin
        test_reset();
        test_full_range();
        test_no_primes();
        test_empty_range();
        test_abort();
        test_single();
        test_back_to_back_start_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
